// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bundles the core request/response handshake and the data SRAM bus.
//   master : core + SRAM side (drives req_*, sram_rdata; observes everything else)
//   slave  : dmem_ctrl side (drives req_ready, resp_*, sram_en/wen/addr/wdata)
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, sram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, sram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the core memory stage and the data SRAM.
//   Byte/half/word loads and stores with lane write enables, sign/zero-extended loads,
//   and a ready/valid handshake tolerating RD_LAT/WR_LAT SRAM cycles.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : dmem_ctrl_if.slave (req_* / resp_* handshake, sram_* bus)
//   Optional: define DMEM_MISALIGN_CHK_EN to flag misaligned half/word accesses with
//   resp_err instead of aligning them down.
module dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input logic        clk,
    input logic        resetn,
    dmem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, nxt;
    logic [2:0]        cnt;
    logic              wr_q, sgn_q;
    logic [1:0]        size_q, a_q;
    logic [1:0]        a;
    logic              mis;
    logic [3:0]        wen;
    logic [31:0]       wdata;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ext;
    logic              en_q;
    logic [3:0]        wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic              valid_q;

    assign a = bus.req_addr[1:0];

`ifdef DMEM_MISALIGN_CHK_EN
    assign mis = (bus.req_size == 2'b01 && a[0]) || (bus.req_size[1] && a != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Store lanes; size 11 falls through to word.
    assign wen   = (bus.req_size == 2'b00) ? 4'b0001 << a :
                   (bus.req_size == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = (bus.req_size == 2'b00) ? {4{bus.req_wdata[7:0]}} :
                   (bus.req_size == 2'b01) ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;

    // Load extract uses the latched request, since the core may change req_* once accepted.
    assign lane_b = bus.sram_rdata[{a_q, 3'b000} +: 8];
    assign lane_h = a_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
    assign ext    = (size_q == 2'b00) ? {{24{sgn_q & lane_b[7]}}, lane_b} :
                    (size_q == 2'b01) ? {{16{sgn_q & lane_h[15]}}, lane_h} : bus.sram_rdata;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) nxt = mis ? RESP : ACCESS;
            end
            ACCESS: begin
                if (cnt == 3'd1) nxt = RESP;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= '0;
            a_q     <= '0;
            en_q    <= 1'b0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= nxt;
            en_q    <= 1'b0;
            wen_q   <= '0;
            valid_q <= (nxt == RESP);
            if (state == ACCESS) cnt <= cnt - 3'd1;
            if (state == IDLE && bus.req_valid) begin
                wr_q   <= bus.req_wr;
                sgn_q  <= bus.req_signed;
                size_q <= bus.req_size;
                a_q    <= a;
                cnt    <= bus.req_wr ? 3'(WR_LAT) : 3'(RD_LAT);
                // A flagged misaligned access skips the SRAM cycle entirely.
                if (!mis) begin
                    en_q    <= 1'b1;
                    wen_q   <= bus.req_wr ? wen : 4'b0000;
                    addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_q <= wdata;
                end
            end
            // Entering RESP from IDLE only happens for a misaligned access: data is 0.
            if (nxt == RESP) rdata_q <= (state == ACCESS && !wr_q) ? ext : 32'b0;
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else if (state == IDLE && bus.req_valid) err_q <= mis;
    end

    assign bus.resp_err = err_q & valid_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.sram_en    = en_q;
    assign bus.sram_wen   = wen_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized self-checking bench for dmem_ctrl against a byte-mask memory model.
module tb_dmem_ctrl;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 1;

    logic clk;
    logic resetn;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat_cnt = 0;
    int   age;
    bit [31:0] mem [64];
    bit [31:0] ref_mem [64];

    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data is only valid in the RD_LAT-th cycle counted from the sram_en cycle.
    always @(posedge clk) begin
        lat_cnt <= bus.sram_en ? 1 : (lat_cnt < 1000 ? lat_cnt + 1 : lat_cnt);
        if (bus.sram_en)
            for (int i = 0; i < 4; i++)
                if (bus.sram_wen[i]) mem[bus.sram_addr[7:2]][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
    end

    assign age            = bus.sram_en ? 1 : lat_cnt + 1;
    assign bus.sram_rdata = (age == RD_LAT) ? mem[bus.sram_addr[7:2]] : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one access from an IDLE cycle (called #1 after a rising edge) and follow it to
    // the cycle after its response. hold keeps req_valid asserted while the controller is busy.
    task automatic do_req(input bit wr, input bit [1:0] size, input bit sgn,
                          input bit [31:0] addr, input bit [31:0] wd, input bit hold);
        bit [1:0]  a    = addr[1:0];
        bit        word = size[1];
        int        sh   = word ? 0 : size[0] ? 16 * a[1] : 8 * a;
        bit [31:0] mask = word ? 32'hFFFF_FFFF : size[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        bit [5:0]  idx  = addr[7:2];
        bit        mis  = 1'b0;
        bit [3:0]  exp_wen;
        bit [31:0] exp_wd, exp_rd;
        int        lat;
`ifdef DMEM_MISALIGN_CHK_EN
        mis = (size == 2'b01 && a[0]) || (word && a != 2'b00);
`endif
        lat = mis ? 1 : (wr ? WR_LAT : RD_LAT) + 1;
        for (int i = 0; i < 4; i++) exp_wen[i] = wr && ((((mask << sh) >> (8 * i)) & 32'hFF) != 0);
        exp_wd = word ? wd : size[0] ? wd[15:0] * 32'h0001_0001 : wd[7:0] * 32'h0101_0101;
        exp_rd = 32'b0;
        if (!wr && !mis) begin
            exp_rd = (ref_mem[idx] >> sh) & mask;
            if (sgn && !word && (exp_rd & ((mask >> 1) + 1)) != 0) exp_rd |= ~mask;
        end
        if (wr && !mis) ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            chk("ready_busy", 32'(bus.req_ready), 32'd0);
            chk("sram_en", 32'(bus.sram_en), 32'(k == 1 && !mis));
            chk("resp_valid", 32'(bus.resp_valid), 32'(k == lat));
            if (k == 1 && !mis) begin
                chk("sram_wen", 32'(bus.sram_wen), 32'(exp_wen));
                chk("sram_addr", bus.sram_addr, addr & 32'hFFFF_FFFC);
                if (wr) chk("sram_wdata", bus.sram_wdata, exp_wd);
            end
            if (k > 1) chk("sram_wen_off", 32'(bus.sram_wen), 32'd0);
            if (k == lat) begin
                chk("resp_rdata", bus.resp_rdata, exp_rd);
                chk("resp_err", 32'(bus.resp_err), 32'(mis));
                bus.req_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("ready_after", 32'(bus.req_ready), 32'd1);
        chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
        chk("rdata_hold", bus.resp_rdata, exp_rd);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_en", 32'(bus.sram_en), 32'd0);
        chk("rst_wen", 32'(bus.sram_wen), 32'd0);
        chk("rst_addr", bus.sram_addr, 32'd0);
        chk("rst_wdata", bus.sram_wdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h8001_1280, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0, 1'b0);
        chk("tp_lb", bus.resp_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
        chk("tp_lbu", bus.resp_rdata, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 1'b0);
        chk("tp_lh", bus.resp_rdata, 32'hFFFF_8001);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1357_9BDF, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
        chk("tp_mis_rdata", bus.resp_rdata, 32'h0);
`else
        chk("tp_mis_rdata", bus.resp_rdata, 32'h1357_9BDF);
`endif
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h0000_1234, 1'b0);

        // Reset in the middle of an RD_LAT load aborts it.
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_0040;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("abort_en", 32'(bus.sram_en), 32'd0);
        chk("abort_addr", bus.sram_addr, 32'd0);
        chk("abort_wdata", bus.sram_wdata, 32'd0);
        chk("abort_rdata", bus.resp_rdata, 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("abort_ready_idle", 32'(bus.req_ready), 32'd1);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255)),
                   $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory access controller between the MIPS core memory stage and the data SRAM.
- Replaces the fixed word-only, single-cycle, all-lanes-write hookup.
- Adds byte, halfword and word accesses with lane-select write enables and sign/zero-extended loads.
- Adds a ready/valid handshake that tolerates a configurable SRAM latency.

Parameters:
- ADDR_W, 32, width of req_addr and sram_addr.
- RD_LAT, 1, SRAM cycles from sram_en to valid sram_rdata; legal range 1..4.
- WR_LAT, 1, cycles a write occupies the SRAM before it is acknowledged; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents an access.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access (only with the optional feature).
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  per-byte write enable.
- sram_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}.
- sram_wdata  out  32  lane-replicated store data.
- sram_rdata  in  32  SRAM read data.

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; wait counter 0.
- Reset asserted mid-access aborts the access: no resp_valid, SRAM outputs cleared immediately.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, req_valid=1 at edge T: latch the request; enter ACCESS; load counter with RD_LAT (load) or WR_LAT (store).
- SRAM outputs are registered. In cycle T+1: sram_en=1, sram_wen (stores only) and sram_addr/sram_wdata are driven.
- sram_en and sram_wen are high for exactly one cycle. sram_addr and sram_wdata hold until RESP.
- ACCESS: counter decrements each cycle. At 1, the next edge samples sram_rdata (load) and enters RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- End-to-end latency: resp_valid in cycle T+LAT+1.
- Back-to-back throughput: one access per LAT+2 cycles.
- req_ready=0 in ACCESS and RESP; req_valid there is ignored; the core must hold the request.
- Store lanes, by a = req_addr[1:0]:
  - byte: sram_wen = 4'b0001<<a; sram_wdata = {4{wdata[7:0]}}.
  - half: sram_wen = a[1] ? 4'b1100 : 4'b0011; sram_wdata = {2{wdata[15:0]}}.
  - word: sram_wen = 4'b1111; sram_wdata = wdata.
- Load extract:
  - byte: lane a.
  - half: lane pair a[1].
  - word: full word.
  - Extended to 32 bits per req_signed; word ignores req_signed.
- Address bits below the access size are otherwise ignored (aligned down).
- resp_rdata holds its value until the next RESP. It is zero for stores.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: half with a[0]=1, or word with a!=0, is misaligned.
  - Accepted normally, but no SRAM cycle (sram_en stays 0).
  - Next cycle is RESP with resp_err=1, resp_rdata=0; latency 1.
- Undefined: resp_err is tied 0; misaligned addresses are aligned down and performed.

Test Plan:
- sb, addr 0x103, wdata 0x000000AB -> sram_wen=1000, sram_wdata=0xABABABAB, sram_addr=0x100, resp_valid at T+2 (WR_LAT=1).
- Mem word 0x8001_1280 at 0x200: lb signed @0x200 -> 0xFFFFFF80; lbu @0x200 -> 0x00000080; lh signed @0x202 -> 0xFFFF8001.
- RD_LAT=3, lw @0x40 -> req_ready low T+1..T+4, sram_en high only T+1, resp_valid only at T+4; second req held during busy is accepted at T+5.
- With DMEM_MISALIGN_CHK_EN, lw @0x42 -> sram_en never high, resp_valid+resp_err at T+1, resp_rdata=0. Without the macro -> reads word @0x40, resp_err=0.
- resetn low at T+2 of an RD_LAT=3 load -> all outputs 0, req_ready=1 after release, no resp_valid ever for the aborted access.
- sh @0x106 data 0x1234 -> sram_wen=1100, sram_wdata=0x12341234.
